// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, funct3 codes and lane helpers for the load/store unit
package mem_access_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic [3:0]  strb;
      logic [31:0] data;
   } store_lanes_t;

   // Unsigned widths exist only for loads; the alignment rule follows the access width.
   function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] offset);
      logic ok;
      ok = 1'b0;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~offset[0];
         F3_W:    ok = (offset == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~offset[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  offset);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rdata[{offset, 3'b000} +: 8];
      h = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_W:    r = rdata;
         F3_BU:   r = {24'd0, b};
         F3_HU:   r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic store_lanes_t store_lanes(input logic [31:0] wdata,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
      store_lanes_t s;
      case (funct3)
         F3_B: begin
            s.strb = 4'b0001 << offset;
            s.data = {4{wdata[7:0]}};
         end
         F3_H: begin
            s.strb = 4'b0011 << offset;
            s.data = {2{wdata[15:0]}};
         end
         F3_W: begin
            s.strb = 4'b1111;
            s.data = wdata;
         end
         default: begin
            s.strb = 4'b0000;
            s.data = 32'd0;
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - execute-side request/response and data-memory port bundle
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              rsp_err;
   logic              dmem_req_valid;
   logic              dmem_req_ready;
   logic [ADDR_W-1:0] dmem_addr;
   logic              dmem_we;
   logic [3:0]        dmem_wstrb;
   logic [31:0]       dmem_wdata;
   logic              dmem_rsp_valid;
   logic [31:0]       dmem_rdata;

   // slave: the load/store unit; master: execute stage plus memory model
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
             dmem_req_ready, dmem_rsp_valid, dmem_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err,
             dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
             dmem_req_ready, dmem_rsp_valid, dmem_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
             dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata
   );
endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - combinational load extraction/extension and store lane replication
module mem_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic        i_we,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata
);
   store_lanes_t w_lanes;

   assign w_lanes     = store_lanes(i_wdata, i_funct3, i_offset);
   // Stores report zero data and loads never drive strobes.
   assign o_load_data = i_we ? 32'd0 : load_extend(i_rdata, i_funct3, i_offset);
   assign o_wstrb     = i_we ? w_lanes.strb : 4'd0;
   assign o_wdata     = w_lanes.data;
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store FSM; MEM_ACCESS_TIMEOUT_EN adds a response watchdog
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   mem_access_unit_if.slave bus
);
   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ISSUE = ST_ISSUE;
   localparam logic [1:0] S_WAIT  = ST_WAIT;
   localparam logic [1:0] S_RESP  = ST_RESP;

   logic [1:0]        r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rsp_data;
   logic              r_rsp_err;

   logic              w_req_ok;
   logic              w_timeout;
   logic [31:0]       w_load_data;
   logic [3:0]        w_wstrb;
   logic [31:0]       w_wdata;

   assign w_req_ok = access_ok(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_ISSUE && bus.dmem_req_ready) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // The count reads LIMIT-1 during the LIMIT-th WAIT cycle; a response that cycle wins.
   assign w_timeout = (r_state == S_WAIT) && !bus.dmem_rsp_valid &&
                      (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_we       <= 1'b0;
         r_funct3   <= 3'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_rsp_data <= 32'd0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_we     <= bus.req_we;
                  r_funct3 <= bus.req_funct3;
                  r_addr   <= bus.req_addr;
                  r_wdata  <= bus.req_wdata;
                  if (w_req_ok) begin
                     r_state <= S_ISSUE;
                  end else begin
                     r_state    <= S_RESP;
                     r_rsp_err  <= 1'b1;
                     r_rsp_data <= 32'd0;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.dmem_req_ready) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.dmem_rsp_valid) begin
                  r_state    <= S_RESP;
                  r_rsp_err  <= 1'b0;
                  r_rsp_data <= w_load_data;
               end else if (w_timeout) begin
                  r_state    <= S_RESP;
                  r_rsp_err  <= 1'b1;
                  r_rsp_data <= 32'd0;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   mem_align u_align (
      .i_funct3    (r_funct3),
      .i_offset    (r_addr[1:0]),
      .i_we        (r_we),
      .i_rdata     (bus.dmem_rdata),
      .i_wdata     (r_wdata),
      .o_load_data (w_load_data),
      .o_wstrb     (w_wstrb),
      .o_wdata     (w_wdata)
   );

   assign bus.req_ready      = (r_state == S_IDLE);
   assign bus.rsp_valid      = (r_state == S_RESP);
   assign bus.rsp_data       = r_rsp_data;
   assign bus.rsp_err        = r_rsp_err;
   assign bus.dmem_req_valid = (r_state == S_ISSUE);
   assign bus.dmem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
   assign bus.dmem_we        = r_we;
   assign bus.dmem_wstrb     = w_wstrb;
   assign bus.dmem_wdata     = w_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_rsp    = 0;
   int   n_dreq   = 0;
   int   rsp0;
   int   dreq0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(32)) bus ();

   mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(negedge clk) begin
      if (bus.rsp_valid) n_rsp++;
      if (bus.dmem_req_valid) n_dreq++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
   endtask

   task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_data);
      int r0;
      drive_req(we, f3, addr, wdata);
      bus.dmem_req_ready = 1'b1;
      check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      r0 = n_rsp;
      check({tag, " issue valid"}, 32'(bus.dmem_req_valid), 32'd1);
      check({tag, " issue addr"}, bus.dmem_addr, addr & 32'hFFFF_FFFC);
      check({tag, " issue we"}, 32'(bus.dmem_we), 32'(we));
      check({tag, " issue wstrb"}, 32'(bus.dmem_wstrb), 32'(exp_strb));
      if (we) check({tag, " issue wdata"}, bus.dmem_wdata, exp_wdata);
      tick();
      bus.dmem_req_ready = 1'b0;
      check({tag, " wait no req"}, 32'(bus.dmem_req_valid), 32'd0);
      check({tag, " wait no rsp"}, 32'(bus.rsp_valid), 32'd0);
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rdata     = rdata;
      tick();
      bus.dmem_rsp_valid = 1'b0;
      bus.dmem_rdata     = 32'h5A5A_5A5A;
      check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, " rsp_data"}, bus.rsp_data, exp_data);
      check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
      tick();
      check({tag, " rsp pulse once"}, 32'(n_rsp - r0), 32'd1);
      check({tag, " back idle"}, 32'(bus.req_ready), 32'd1);
      check({tag, " rsp_data hold"}, bus.rsp_data, exp_data);
   endtask

   task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
      int d0;
      d0 = n_dreq;
      drive_req(we, f3, addr, 32'hFFFF_FFFF);
      bus.dmem_req_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd1);
      check({tag, " rsp_data"}, bus.rsp_data, 32'd0);
      tick();
      bus.dmem_req_ready = 1'b0;
      check({tag, " idle"}, 32'(bus.req_ready), 32'd1);
      check({tag, " no dmem req"}, 32'(n_dreq - d0), 32'd0);
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.req_valid      = 1'b0;
      bus.req_we         = 1'b0;
      bus.req_funct3     = 3'd0;
      bus.req_addr       = 32'd0;
      bus.req_wdata      = 32'd0;
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      bus.dmem_rdata     = 32'd0;
      tick();
      tick();
      check("reset req_ready", 32'(bus.req_ready), 32'd1);
      check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset rsp_data", bus.rsp_data, 32'd0);
      check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
      check("reset dmem_req_valid", 32'(bus.dmem_req_valid), 32'd0);
      check("reset dmem_addr", bus.dmem_addr, 32'd0);
      check("reset dmem_wstrb", 32'(bus.dmem_wstrb), 32'd0);
      check("reset dmem_we", 32'(bus.dmem_we), 32'd0);
      rst_n = 1'b1;
      tick();

      run_access("LB 103", 1'b0, F3_B, 32'h103, 32'd0, 32'h80FF_1234, 4'b0000, 32'd0, 32'hFFFF_FF80);
      run_access("LB 100", 1'b0, F3_B, 32'h100, 32'd0, 32'h0000_007F, 4'b0000, 32'd0, 32'h0000_007F);
      run_access("LHU 102", 1'b0, F3_HU, 32'h102, 32'd0, 32'hBEEF_0000, 4'b0000, 32'd0, 32'h0000_BEEF);
      run_access("LH 102", 1'b0, F3_H, 32'h102, 32'd0, 32'hBEEF_0000, 4'b0000, 32'd0, 32'hFFFF_BEEF);
      run_access("LBU 101", 1'b0, F3_BU, 32'h101, 32'd0, 32'h0000_C300, 4'b0000, 32'd0, 32'h0000_00C3);
      run_access("LW 200", 1'b0, F3_W, 32'h200, 32'd0, 32'h1234_5678, 4'b0000, 32'd0, 32'h1234_5678);
      run_access("SB 101", 1'b1, F3_B, 32'h101, 32'h0000_00A5, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 32'd0);
      run_access("SH 102", 1'b1, F3_H, 32'h102, 32'h1234_5678, 32'hFFFF_FFFF, 4'b1100, 32'h5678_5678, 32'd0);
      run_access("SW 204", 1'b1, F3_W, 32'h204, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'b1111, 32'hDEAD_BEEF, 32'd0);

      run_access("LW 300", 1'b0, F3_W, 32'h300, 32'd0, 32'h0BAD_F00D, 4'b0000, 32'd0, 32'h0BAD_F00D);
      run_err("LW misaligned", 1'b0, F3_W, 32'h102);
      run_err("SW f3 011", 1'b1, 3'b011, 32'h100);
      run_err("LH odd", 1'b0, F3_H, 32'h101);
      run_err("SH odd", 1'b1, F3_H, 32'h103);
      run_err("S f3 100", 1'b1, 3'b100, 32'h100);
      run_err("L f3 110", 1'b0, 3'b110, 32'h100);

      // Memory stalls the request for 5 cycles, then answers after 4 silent WAIT cycles.
      drive_req(1'b1, F3_W, 32'h40, 32'hCAFE_F00D);
      bus.dmem_req_ready = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      rsp0 = n_rsp;
      for (int i = 0; i < 5; i++) begin
         check("stall valid", 32'(bus.dmem_req_valid), 32'd1);
         check("stall addr", bus.dmem_addr, 32'h40);
         check("stall wstrb", 32'(bus.dmem_wstrb), 32'hF);
         check("stall wdata", bus.dmem_wdata, 32'hCAFE_F00D);
         check("stall req_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      check("stall still issuing", 32'(bus.dmem_req_valid), 32'd1);
      bus.dmem_req_ready = 1'b1;
      bus.dmem_rsp_valid = 1'b1;
      tick();
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check("wait dmem_req_valid", 32'(bus.dmem_req_valid), 32'd0);
         check("wait req_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.dmem_rsp_valid = 1'b1;
      tick();
      bus.dmem_rsp_valid = 1'b0;
      check("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall rsp_err", 32'(bus.rsp_err), 32'd0);
      check("stall rsp_data", bus.rsp_data, 32'd0);
      check("stall req_ready in resp", 32'(bus.req_ready), 32'd0);
      tick();
      check("stall single pulse", 32'(n_rsp - rsp0), 32'd1);
      check("stall idle", 32'(bus.req_ready), 32'd1);

      // Reset while waiting abandons the access; a late response is ignored.
      run_access("LW 80", 1'b0, F3_W, 32'h80, 32'd0, 32'h7777_1111, 4'b0000, 32'd0, 32'h7777_1111);
      drive_req(1'b0, F3_W, 32'h84, 32'd0);
      bus.dmem_req_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      bus.dmem_req_ready = 1'b0;
      check("pre-reset in wait", 32'(bus.req_ready), 32'd0);
      rsp0 = n_rsp;
      rst_n = 1'b0;
      #1;
      check("async reset req_ready", 32'(bus.req_ready), 32'd1);
      check("async reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("async reset rsp_data", bus.rsp_data, 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rdata     = 32'h9999_9999;
      tick();
      bus.dmem_rsp_valid = 1'b0;
      check("late rsp ignored", 32'(bus.rsp_valid), 32'd0);
      check("late rsp idle", 32'(bus.req_ready), 32'd1);
      tick();
      check("no rsp after reset", 32'(n_rsp - rsp0), 32'd0);
      check("rsp_data after reset", bus.rsp_data, 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
      drive_req(1'b0, F3_W, 32'h10, 32'd0);
      bus.dmem_req_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      bus.dmem_req_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("timeout wait", 32'(bus.rsp_valid), 32'd0);
         tick();
      end
      check("timeout rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("timeout rsp_err", 32'(bus.rsp_err), 32'd1);
      check("timeout rsp_data", bus.rsp_data, 32'd0);
      tick();
      check("timeout idle", 32'(bus.req_ready), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store unit in the MEM stage. Produces the loaded word that the write-back select consumes as its memory-data input.
- Accepts one access at a time from the execute stage and drives a valid/ready data-memory port.
- Loads: aligns and sign/zero-extends the returned data. Stores: generates byte strobes.
- Signals completion with a one-cycle response pulse; misaligned or illegal accesses complete with an error and no memory traffic.

Parameters:
- ADDR_W, 32, width of byte address.
- TIMEOUT_CYCLES, 255, watchdog limit on memory response wait (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  access request from execute.
- req_ready  out  1  unit idle, request accepted this cycle if req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned / illegal funct3 / timeout; qualified by rsp_valid.
- dmem_req_valid  out  1  memory request.
- dmem_req_ready  in  1  memory accepts request.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dmem_we  out  1  write enable.
- dmem_wstrb  out  4  byte strobes (0 for loads).
- dmem_wdata  out  32  store data replicated into lanes.
- dmem_rsp_valid  in  1  read data / write ack returned.
- dmem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except req_ready = 1. Captured request registers cleared. Reset mid-access abandons it; no rsp_valid is issued. A late dmem_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state == IDLE).
- IDLE: on req_valid, capture we, funct3, addr and wdata.
  - Legal and aligned -> ISSUE.
  - Otherwise -> RESP with error flag set.
- Legality:
  - Loads accept funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores accept 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- ISSUE: dmem_req_valid = 1, with address/we/wstrb/wdata held stable until dmem_req_ready. Handshake cycle -> WAIT. The request must not be withdrawn while ready is low.
- WAIT: dmem_req_valid = 0. On dmem_rsp_valid, register the extended load result -> RESP. dmem_rsp_valid in the same cycle as the ISSUE handshake is not accepted; it is only sampled in WAIT.
- RESP: rsp_valid = 1 for exactly one cycle with rsp_data/rsp_err -> IDLE. A new request is accepted no earlier than the cycle after RESP.
- Minimum latency, accept to rsp_valid: 3 cycles (request ready immediately, data returned the cycle after). Error path: 1 cycle.
- Load extraction: byte lane = addr[1:0], halfword lane = addr[1]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- rsp_data and rsp_err hold their last values outside RESP and are qualified by rsp_valid.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without dmem_rsp_valid -> RESP with rsp_err = 1, rsp_data = 0. A response arriving in the same cycle as the limit wins (no error).
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package mem_access_pkg:
  - State enum.
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Function load_extend(rdata, funct3, offset).
  - Function store_lanes(wdata, funct3, offset), returning strobe + data.
- One natural sub-module: mem_align, the combinational lane/extension logic for both directions. The FSM stays in the top.

Test Plan:
- LB at addr 0x103, dmem_rdata 0x80FF_1234, memory ready immediately -> rsp_valid 3 cycles after accept, rsp_data 0xFFFF_FF80, dmem_addr 0x100.
- LHU at 0x102, rdata 0xBEEF_0000 -> rsp_data 0x0000_BEEF. LH at same address -> 0xFFFF_BEEF.
- SB at 0x101, wdata 0x0000_00A5 -> dmem_wstrb 0010, dmem_wdata 0xA5A5_A5A5, dmem_we 1; rsp_data 0, rsp_err 0 after ack.
- LW at 0x102 -> rsp_valid next cycle with rsp_err 1, no dmem_req_valid ever asserted. Store funct3 011 -> same error behaviour.
- dmem_req_ready held low 5 cycles, then response after 4 WAIT cycles -> request fields stable throughout, single rsp_valid, req_ready low until after RESP.
- rst_n pulsed low during WAIT -> req_ready 1, rsp_valid never asserted; with MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES 8, silent memory -> rsp_err 1 after 8 WAIT cycles.
